// File: rtl/gpu_bus_bridge.sv
// Host-CPU to GPU register bridge.
// A 6502-side strobe (cs_clock, active low, asynchronous) is synchronised together with the
// addr/data_in/rw bus; each falling edge of the synchronised strobe commits one register access.
// DATA writes store through an auto-incrementing 16-bit VRAM pointer into the tile, attribute
// or colour memory write port; FILL repeats the DATA latch for N consecutive cycles.
// Ports:
//   clk, rst_n                    system clock, asynchronous active-low reset
//   cs_clock, rw, addr, data_in   CPU bus (strobe active low; rw 1 = read)
//   data_out, data_oe             read-back data and its drive enable
//   busy                          fill engine writing
//   *_memory_write_{enable,addr,data}  one-cycle write ports per VRAM region
module gpu_bus_bridge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TILE_AW     = 11,
    parameter int unsigned ATTR_AW     = 12,
    parameter int unsigned COLOR_AW    = 4,
    parameter logic [15:0] TILE_BASE   = 16'h0000,
    parameter logic [15:0] ATTR_BASE   = 16'h0800,
    parameter logic [15:0] COLOR_BASE  = 16'h1800
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cs_clock,
    input  logic                rw,
    input  logic [2:0]          addr,
    input  logic [7:0]          data_in,
    output logic [7:0]          data_out,
    output logic                data_oe,
    output logic                busy,
    output logic                tile_memory_write_enable,
    output logic [TILE_AW-1:0]  tile_memory_write_addr,
    output logic [7:0]          tile_memory_write_data,
    output logic                attribute_memory_write_enable,
    output logic [ATTR_AW-1:0]  attribute_memory_write_addr,
    output logic [7:0]          attribute_memory_write_data,
    output logic                color_memory_write_enable,
    output logic [COLOR_AW-1:0] color_memory_write_addr,
    output logic [7:0]          color_memory_write_data
);

    typedef enum logic {StIdle, StFill} state_e;

    localparam logic [16:0] TileSize  = 17'd1 << TILE_AW;
    localparam logic [16:0] AttrSize  = 17'd1 << ATTR_AW;
    localparam logic [16:0] ColorSize = 17'd1 << COLOR_AW;

    // Bus synchroniser; the strobe chain idles high.
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] rw_sync_q;
    logic [2:0]             addr_sync_q [SYNC_STAGES];
    logic [7:0]             data_sync_q [SYNC_STAGES];
    logic                   cs_prev_q;

    // Registered command, processed the cycle after the strobe fall is seen.
    logic       commit_q;
    logic       cmd_rw_q;
    logic [2:0] cmd_addr_q;
    logic [7:0] cmd_data_q;

    state_e      state_q, state_d;
    logic [15:0] ptr_q, ptr_d;
    logic [7:0]  inc_q, inc_d;
    logic [7:0]  data_q, data_d;
    logic [8:0]  count_q, count_d;
    logic        miss_q, miss_d;
    logic        ovr_q, ovr_d;
    logic        busy_q;

    logic        wr_req;
    logic [7:0]  wr_val;
    logic        clr_status, set_miss, set_ovr;
    logic        tile_we_d, attr_we_d, color_we_d;
    logic [16:0] tile_diff, attr_diff, color_diff;
    logic        tile_hit, attr_hit, color_hit;

    logic                tile_we_q, attr_we_q, color_we_q;
    logic [TILE_AW-1:0]  tile_addr_q;
    logic [ATTR_AW-1:0]  attr_addr_q;
    logic [COLOR_AW-1:0] color_addr_q;
    logic [7:0]          tile_data_q, attr_data_q, color_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q <= '1;
            rw_sync_q <= '0;
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                addr_sync_q[i] <= '0;
                data_sync_q[i] <= '0;
            end
            cs_prev_q  <= 1'b1;
            commit_q   <= 1'b0;
            cmd_rw_q   <= 1'b0;
            cmd_addr_q <= '0;
            cmd_data_q <= '0;
        end else begin
            cs_sync_q      <= {cs_sync_q[SYNC_STAGES-2:0], cs_clock};
            rw_sync_q      <= {rw_sync_q[SYNC_STAGES-2:0], rw};
            addr_sync_q[0] <= addr;
            data_sync_q[0] <= data_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                addr_sync_q[i] <= addr_sync_q[i-1];
                data_sync_q[i] <= data_sync_q[i-1];
            end
            cs_prev_q  <= cs_sync_q[SYNC_STAGES-1];
            commit_q   <= cs_prev_q & ~cs_sync_q[SYNC_STAGES-1];
            cmd_rw_q   <= rw_sync_q[SYNC_STAGES-1];
            cmd_addr_q <= addr_sync_q[SYNC_STAGES-1];
            cmd_data_q <= data_sync_q[SYNC_STAGES-1];
        end
    end

    // Region decode; a borrow out of the 17-bit subtraction means PTR is below the base.
    assign tile_diff  = {1'b0, ptr_q} - {1'b0, TILE_BASE};
    assign attr_diff  = {1'b0, ptr_q} - {1'b0, ATTR_BASE};
    assign color_diff = {1'b0, ptr_q} - {1'b0, COLOR_BASE};
    assign tile_hit   = ~tile_diff[16]  && ({1'b0, tile_diff[15:0]}  < TileSize);
    assign attr_hit   = ~attr_diff[16]  && ({1'b0, attr_diff[15:0]}  < AttrSize);
    assign color_hit  = ~color_diff[16] && ({1'b0, color_diff[15:0]} < ColorSize);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        inc_d      = inc_q;
        data_d     = data_q;
        count_d    = count_q;
        wr_req     = 1'b0;
        wr_val     = data_q;
        clr_status = 1'b0;
        set_miss   = 1'b0;
        set_ovr    = 1'b0;
        tile_we_d  = 1'b0;
        attr_we_d  = 1'b0;
        color_we_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (commit_q) begin
                    if (cmd_rw_q) begin
                        clr_status = (cmd_addr_q == 3'd0);
                    end else begin
                        case (cmd_addr_q)
                            3'd3: inc_d = cmd_data_q;
                            3'd4: ptr_d[7:0] = cmd_data_q;
                            3'd5: ptr_d[15:8] = cmd_data_q;
                            3'd6: begin
                                data_d = cmd_data_q;
                                wr_req = 1'b1;
                                wr_val = cmd_data_q;
                            end
                            3'd7: begin
                                count_d = (cmd_data_q == 8'd0) ? 9'd256 : {1'b0, cmd_data_q};
                                state_d = StFill;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            StFill: begin
                wr_req  = 1'b1;
                count_d = count_q - 9'd1;
                if (count_q == 9'd1) begin
                    state_d = StIdle;
                end
                if (commit_q) begin
                    if (cmd_rw_q) begin
                        clr_status = (cmd_addr_q == 3'd0);
                    end else begin
                        set_ovr = (cmd_addr_q >= 3'd3);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (wr_req) begin
            ptr_d = ptr_q + {8'h00, inc_q};
            if (tile_hit) begin
                tile_we_d = 1'b1;
            end else if (attr_hit) begin
                attr_we_d = 1'b1;
            end else if (color_hit) begin
                color_we_d = 1'b1;
            end else begin
                set_miss = 1'b1;
            end
        end

        // A set in the same cycle as a STATUS read wins over the clear.
        miss_d = (miss_q & ~clr_status) | set_miss;
        ovr_d  = (ovr_q & ~clr_status) | set_ovr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            inc_q        <= 8'd1;
            data_q       <= '0;
            count_q      <= '0;
            miss_q       <= 1'b0;
            ovr_q        <= 1'b0;
            busy_q       <= 1'b0;
            tile_we_q    <= 1'b0;
            attr_we_q    <= 1'b0;
            color_we_q   <= 1'b0;
            tile_addr_q  <= '0;
            attr_addr_q  <= '0;
            color_addr_q <= '0;
            tile_data_q  <= '0;
            attr_data_q  <= '0;
            color_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            inc_q      <= inc_d;
            data_q     <= data_d;
            count_q    <= count_d;
            miss_q     <= miss_d;
            ovr_q      <= ovr_d;
            // Registered alongside the write ports so busy covers exactly the fill writes.
            busy_q     <= (state_q == StFill);
            tile_we_q  <= tile_we_d;
            attr_we_q  <= attr_we_d;
            color_we_q <= color_we_d;
            if (tile_we_d) begin
                tile_addr_q <= tile_diff[TILE_AW-1:0];
                tile_data_q <= wr_val;
            end
            if (attr_we_d) begin
                attr_addr_q <= attr_diff[ATTR_AW-1:0];
                attr_data_q <= wr_val;
            end
            if (color_we_d) begin
                color_addr_q <= color_diff[COLOR_AW-1:0];
                color_data_q <= wr_val;
            end
        end
    end

    // Read-back is pure selection on the raw address; side effects wait for the commit.
    always_comb begin
        data_out = 8'h00;
        case (addr)
            3'd0:    data_out = {5'b0, ovr_q, miss_q, busy_q | (state_q == StFill)};
            3'd3:    data_out = inc_q;
            3'd4:    data_out = ptr_q[7:0];
            3'd5:    data_out = ptr_q[15:8];
            3'd6:    data_out = data_q;
            3'd7:    data_out = count_q[7:0];
            default: data_out = 8'h00;
        endcase
    end

    assign data_oe = ~cs_clock & rw & rst_n;
    assign busy    = busy_q;

    assign tile_memory_write_enable      = tile_we_q;
    assign tile_memory_write_addr        = tile_addr_q;
    assign tile_memory_write_data        = tile_data_q;
    assign attribute_memory_write_enable = attr_we_q;
    assign attribute_memory_write_addr   = attr_addr_q;
    assign attribute_memory_write_data   = attr_data_q;
    assign color_memory_write_enable     = color_we_q;
    assign color_memory_write_addr       = color_addr_q;
    assign color_memory_write_data       = color_data_q;

endmodule

// File: tb/tb_gpu_bus_bridge.sv
module tb_gpu_bus_bridge;

    localparam int unsigned S = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs_clock = 1'b1;
    logic        rw = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        busy;
    logic        t_we, a_we, c_we;
    logic [10:0] t_addr;
    logic [11:0] a_addr;
    logic [3:0]  c_addr;
    logic [7:0]  t_data, a_data, c_data;

    int checks = 0;
    int failures = 0;

    gpu_bus_bridge #(
        .SYNC_STAGES(S),
        .TILE_AW    (11),
        .ATTR_AW    (12),
        .COLOR_AW   (4),
        .TILE_BASE  (16'h0000),
        .ATTR_BASE  (16'h0800),
        .COLOR_BASE (16'h1800)
    ) dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .cs_clock                     (cs_clock),
        .rw                           (rw),
        .addr                         (addr),
        .data_in                      (data_in),
        .data_out                     (data_out),
        .data_oe                      (data_oe),
        .busy                         (busy),
        .tile_memory_write_enable     (t_we),
        .tile_memory_write_addr       (t_addr),
        .tile_memory_write_data       (t_data),
        .attribute_memory_write_enable(a_we),
        .attribute_memory_write_addr  (a_addr),
        .attribute_memory_write_data  (a_data),
        .color_memory_write_enable    (c_we),
        .color_memory_write_addr      (c_addr),
        .color_memory_write_data      (c_data)
    );

    always #5 clk = ~clk;

    // Write-port monitor, sampled on the falling edge.
    int          cyc = 0;
    int          t_tot = 0, a_tot = 0, c_tot = 0, busy_tot = 0, multi_hot = 0;
    logic [10:0] t_log_addr [1024];
    logic [7:0]  t_log_data [1024];
    int          t_log_cyc  [1024];
    logic [11:0] a_last_addr = '0;
    logic [7:0]  a_last_data = '0;
    logic [3:0]  c_last_addr = '0;
    logic [7:0]  c_last_data = '0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if ((int'(t_we) + int'(a_we) + int'(c_we)) > 1) multi_hot = multi_hot + 1;
        if (busy) busy_tot = busy_tot + 1;
        if (t_we && t_tot < 1024) begin
            t_log_addr[t_tot] = t_addr;
            t_log_data[t_tot] = t_data;
            t_log_cyc[t_tot]  = cyc;
            t_tot = t_tot + 1;
        end
        if (a_we) begin
            a_last_addr = a_addr;
            a_last_data = a_data;
            a_tot = a_tot + 1;
        end
        if (c_we) begin
            c_last_addr = c_addr;
            c_last_data = c_data;
            c_tot = c_tot + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        addr = a;
        data_in = d;
        rw = 1'b0;
        cs_clock = 1'b0;
        repeat (6) @(posedge clk);
        #1 cs_clock = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    logic last_oe;

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        @(posedge clk);
        #1;
        addr = a;
        rw = 1'b1;
        cs_clock = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        d = data_out;
        last_oe = data_oe;
        repeat (4) @(posedge clk);
        #1 cs_clock = 1'b1;
        repeat (4) @(posedge clk);
        #1 rw = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        int first, width, tb, ab, cb, n, bad, bb;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_tile_we", 32'(t_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_oe", 32'(data_oe), 32'd0);
        check("rst_status", 32'(data_out), 32'h00);
        addr = 3'd3;
        #1 check("rst_inc", 32'(data_out), 32'h01);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        bus_read(3'd3, rd);
        check("read_oe", 32'(last_oe), 32'd1);
        check("read_inc", 32'(rd), 32'h01);

        // PTR = 0100, DATA = AA with latency and pulse-width measurement.
        bus_write(3'd4, 8'h00);
        bus_write(3'd5, 8'h01);
        tb = t_tot;
        @(posedge clk);
        #1;
        addr = 3'd6;
        data_in = 8'hAA;
        rw = 1'b0;
        cs_clock = 1'b0;
        first = -1;
        width = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            if (t_we) begin
                if (first < 0) first = k;
                width++;
            end
        end
        cs_clock = 1'b1;
        repeat (4) @(posedge clk);
        check("lat_first", 32'(first), 32'(S + 1));
        check("lat_width", 32'(width), 32'd1);
        check("tile_cnt_aa", 32'(t_tot - tb), 32'd1);
        check("tile_addr_aa", 32'(t_log_addr[tb]), 32'h100);
        check("tile_data_aa", 32'(t_log_data[tb]), 32'hAA);
        bus_read(3'd4, rd);
        check("ptr_lo_0101", 32'(rd), 32'h01);
        bus_read(3'd5, rd);
        check("ptr_hi_0101", 32'(rd), 32'h01);
        bus_read(3'd6, rd);
        check("data_rb", 32'(rd), 32'hAA);

        // Attribute then colour region.
        bus_write(3'd4, 8'h00);
        bus_write(3'd5, 8'h09);
        ab = a_tot;
        bus_write(3'd6, 8'h0E);
        check("attr_cnt", 32'(a_tot - ab), 32'd1);
        check("attr_addr", 32'(a_last_addr), 32'h100);
        check("attr_data", 32'(a_last_data), 32'h0E);
        bus_write(3'd4, 8'h02);
        bus_write(3'd5, 8'h18);
        cb = c_tot;
        bus_write(3'd6, 8'hBE);
        check("color_cnt", 32'(c_tot - cb), 32'd1);
        check("color_addr", 32'(c_last_addr), 32'h2);
        check("color_data", 32'(c_last_data), 32'hBE);

        // INC = 2 across the tile/attribute boundary.
        bus_write(3'd3, 8'h02);
        bus_write(3'd4, 8'hFE);
        bus_write(3'd5, 8'h07);
        tb = t_tot;
        ab = a_tot;
        bus_write(3'd6, 8'h11);
        bus_write(3'd6, 8'h22);
        check("bnd_tile_cnt", 32'(t_tot - tb), 32'd1);
        check("bnd_tile_addr", 32'(t_log_addr[tb]), 32'h7FE);
        check("bnd_tile_data", 32'(t_log_data[tb]), 32'h11);
        check("bnd_attr_cnt", 32'(a_tot - ab), 32'd1);
        check("bnd_attr_addr", 32'(a_last_addr), 32'h000);
        check("bnd_attr_data", 32'(a_last_data), 32'h22);
        bus_read(3'd4, rd);
        check("ptr_lo_0802", 32'(rd), 32'h02);
        bus_read(3'd5, rd);
        check("ptr_hi_0802", 32'(rd), 32'h08);

        // Unmapped address: write dropped, miss set, cleared by STATUS read.
        bus_write(3'd4, 8'h10);
        bus_write(3'd5, 8'h18);
        tb = t_tot;
        ab = a_tot;
        cb = c_tot;
        bus_write(3'd6, 8'h55);
        check("miss_no_write", 32'((t_tot - tb) + (a_tot - ab) + (c_tot - cb)), 32'd0);
        bus_read(3'd0, rd);
        check("status_miss", 32'(rd), 32'h02);
        bus_read(3'd0, rd);
        check("status_clr", 32'(rd), 32'h00);

        // Fill of 4 after DATA = 33 at PTR 0000.
        bus_write(3'd3, 8'h01);
        bus_write(3'd4, 8'h00);
        bus_write(3'd5, 8'h00);
        bus_write(3'd6, 8'h33);
        tb = t_tot;
        bb = busy_tot;
        bus_write(3'd7, 8'h04);
        repeat (10) @(posedge clk);
        #1;
        check("fill_busy_done", 32'(busy), 32'd0);
        check("fill_cnt", 32'(t_tot - tb), 32'd4);
        check("fill_busy_cycles", 32'(busy_tot - bb), 32'd4);
        check("fill_consecutive", 32'(t_log_cyc[tb + 3] - t_log_cyc[tb]), 32'd3);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (t_log_addr[tb + i] !== 11'(i + 1) || t_log_data[tb + i] !== 8'h33) bad++;
        end
        check("fill_addrs", 32'(bad), 32'd0);
        bus_read(3'd4, rd);
        check("fill_ptr_lo", 32'(rd), 32'h05);
        bus_read(3'd7, rd);
        check("fill_count_rb", 32'(rd), 32'h00);

        // Fill of 256 with an ignored PTR_LO write, then reset mid-fill.
        tb = t_tot;
        ab = a_tot;
        cb = c_tot;
        bus_write(3'd7, 8'h00);
        bus_write(3'd4, 8'h77);
        bus_read(3'd0, rd);
        check("status_overrun", 32'(rd), 32'h05);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_we", 32'(t_we), 32'd0);
        n = t_tot - tb;
        check("abort_partial", 32'(n > 4 && n < 256), 32'd1);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (t_log_addr[tb + i] !== 11'(i + 5) || t_log_data[tb + i] !== 8'h33) bad++;
        end
        check("abort_seq", 32'(bad), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        check("abort_no_more", 32'(t_tot - tb), 32'(n));
        check("abort_no_other", 32'((a_tot - ab) + (c_tot - cb)), 32'd0);
        bus_read(3'd4, rd);
        check("abort_ptr_lo", 32'(rd), 32'h00);
        bus_read(3'd5, rd);
        check("abort_ptr_hi", 32'(rd), 32'h00);
        bus_read(3'd0, rd);
        check("abort_status", 32'(rd), 32'h00);
        check("one_hot_writes", 32'(multi_hot), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpu_bus_bridge.md
# gpu_bus_bridge

- Parametrised host-CPU-to-GPU register bridge; next generation of the GPU bus interface.
- The 6502-side strobe (`cs_clock`, active low) is asynchronous to `clk`. The bridge synchronises it and decodes a 3-bit register window.
- Writes go to tile, attribute and colour memory write ports through an auto-incrementing 16-bit VRAM pointer.
- Adds a programmable increment, a hardware fill engine, register read-back and sticky error status.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser depth for `cs_clock`, `addr`, `data_in`, `rw` (≥2).
- `TILE_AW`, 11: tile memory address width.
- `ATTR_AW`, 12: attribute memory address width.
- `COLOR_AW`, 4: colour memory address width.
- `TILE_BASE`, 16'h0000: first VRAM address of tile region.
- `ATTR_BASE`, 16'h0800: first VRAM address of attribute region.
- `COLOR_BASE`, 16'h1800: first VRAM address of colour region.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock (100 MHz).
- `rst_n`  in  1  asynchronous active-low reset.
- `cs_clock`  in  1  bus strobe, active low, asynchronous.
- `rw`  in  1  1 = CPU read, 0 = CPU write.
- `addr`  in  3  register select.
- `data_in`  in  8  CPU write data.
- `data_out`  out  8  read-back data.
- `data_oe`  out  1  read-back drive enable.
- `busy`  out  1  fill engine active.
- `tile_memory_write_enable`  out  1  single-cycle write strobe.
- `tile_memory_write_addr`  out  TILE_AW  tile write address.
- `tile_memory_write_data`  out  8  tile write data.
- `attribute_memory_write_enable`  out  1  single-cycle write strobe.
- `attribute_memory_write_addr`  out  ATTR_AW  attribute write address.
- `attribute_memory_write_data`  out  8  attribute write data.
- `color_memory_write_enable`  out  1  single-cycle write strobe.
- `color_memory_write_addr`  out  COLOR_AW  colour write address.
- `color_memory_write_data`  out  8  colour write data.

## Operation
- Register map:
  - 0 STATUS (R): bit0 busy, bit1 miss, bit2 overrun, others 0.
  - 1, 2: reserved; read 0, writes ignored.
  - 3 INC (R/W): pointer increment, reset 1; 0 means no increment.
  - 4 PTR_LO (R/W).
  - 5 PTR_HI (R/W).
  - 6 DATA (W: store to VRAM; R: last value written).
  - 7 FILL (W: start fill of N words, 0 means 256; R: remaining count low byte).
- Commit: one bus access per falling edge of the synchronised `cs_clock`. It uses the `addr`/`data_in`/`rw` values pipelined through the same stage count.
- DATA write, idle:
  - Latch data.
  - Decode PTR into a region and issue one write to that region: address = PTR − base, truncated to region width.
  - Then PTR += INC, mod 2^16.
- Region decode:
  - A region matches when base ≤ PTR < base + 2^AW.
  - Tile has priority over attribute, attribute over colour.
  - No match: write dropped, miss set, PTR still advances.
- FSM has two states, IDLE and FILL.
  - FILL commit in IDLE loads count = N and enters FILL.
  - Each FILL cycle: write DATA latch at PTR (same decode/miss rules), PTR += INC, count−1.
  - FILL returns to IDLE after the final write.
- Any write commit to registers 3–7 during FILL is ignored and sets overrun. Reads are always serviced.
- A STATUS read commit clears miss and overrun. A bit set in the same cycle stays set.
- `data_oe` = !`cs_clock` & `rw` & `rst_n`, combinational.
  - `data_out` = register selected by raw `addr`, muxed from registered state.
  - Not in TILE_BASE order: mux is pure selection, no side effects until commit.
- Reset mid-fill aborts the fill immediately. No further writes issue.

## Timing
- Reset values:
  - All outputs 0, except `data_out`, which reflects registers (STATUS = 0).
  - Internal: PTR = 0, INC = 1, DATA latch = 0, count = 0, state IDLE.
  - Synchroniser flops reset to 1 (strobe idle).
- Bus requirements:
  - `addr`/`data_in`/`rw` stable from `cs_clock` fall until ≥ SYNC_STAGES+1 clk later.
  - `cs_clock` low ≥ 2 clk and high ≥ 2 clk.
- Latency: write enable asserts exactly SYNC_STAGES+1 clk edges after the first edge sampling `cs_clock` low.
  - Enable is one cycle wide.
  - Write address and data are valid in the same cycle.
- Fill timing:
  - First fill write occurs the cycle after the FILL commit; N writes follow on N consecutive cycles.
  - `busy` is high from the cycle after the commit through the last write cycle.
  - `busy` is low the following cycle.
- Only one memory write enable is ever high in a given cycle.
- PTR wraps FFFF → 0000 without error. With INC = 0, a fill rewrites the same address N times.

## Test plan
- Reset, then write PTR = 0100 and DATA = AA.
  - Expect one `tile_memory_write_enable` pulse, addr 100, data AA.
  - Expect PTR read-back = 0101.
- PTR = 0900, DATA = 0E → attribute write at addr 100.
  - Then PTR = 1802, DATA = BE → colour write at addr 2, data BE.
- INC = 2, PTR = 07FE, DATA 11 then 22.
  - Expect tile write at 7FE, then attribute write at 000.
  - Expect PTR = 0802.
- PTR = 1810, DATA = 55.
  - Expect no write enable and STATUS = 02.
  - Second STATUS read = 00.
- DATA = 33 at PTR 0000, then FILL = 4.
  - Expect 4 consecutive tile writes at 001..004 of 33.
  - `busy` high 4 cycles; PTR read-back = 0005.
- FILL = 0 started, then PTR_LO write mid-fill.
  - PTR_LO write ignored; STATUS bit2 set.
  - Assert `rst_n` low mid-fill: writes stop at once, `busy` = 0, PTR = 0.
